// File: rtl/mem_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_store_unit
// Purpose  : MEM-stage load/store unit driving a word-wide data memory.
//            Sub-word stores use read-modify-write; loads are lane-extracted.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req_Valid,
    input  logic                  Req_Write,
    input  logic [1:0]            Req_Size,
    input  logic                  Req_Signed,
    input  logic [ADDR_WIDTH-1:0] Req_Addr,
    input  logic [31:0]           Req_Wdata,
    output logic                  Stall,
    output logic                  Resp_Valid,
    output logic [31:0]           Resp_Rdata,
    output logic                  Access_Error,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic [31:0]           Mem_Write_Data,
    input  logic [31:0]           Mem_Read_Data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [1:0]              lane_q;
    logic                    resp_valid_q;
    logic                    access_error_q;
    logic [31:0]             resp_rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [31:0]             mem_write_data_q;

    logic                    req_err;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             rd_extract_d;
    logic [31:0]             wr_merge_d;

    always_comb begin
        req_err = 1'b0;
        case (Req_Size)
            SZ_HALF: req_err = Req_Addr[0];
            SZ_WORD: req_err = |Req_Addr[1:0];
            SZ_BYTE: req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_byte = Mem_Read_Data[7:0];
        case (lane_q)
            2'd0: rd_byte = Mem_Read_Data[7:0];
            2'd1: rd_byte = Mem_Read_Data[15:8];
            2'd2: rd_byte = Mem_Read_Data[23:16];
            default: rd_byte = Mem_Read_Data[31:24];
        endcase
        rd_half = lane_q[1] ? Mem_Read_Data[31:16] : Mem_Read_Data[15:0];

        rd_extract_d = Mem_Read_Data;
        if (size_q == SZ_BYTE) begin
            rd_extract_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
        end else if (size_q == SZ_HALF) begin
            rd_extract_d = {{16{signed_q & rd_half[15]}}, rd_half};
        end
    end

    // Store data sits right-justified in mem_write_data_q until the old word arrives.
    always_comb begin
        wr_merge_d = Mem_Read_Data;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0: wr_merge_d[7:0]   = mem_write_data_q[7:0];
                2'd1: wr_merge_d[15:8]  = mem_write_data_q[7:0];
                2'd2: wr_merge_d[23:16] = mem_write_data_q[7:0];
                default: wr_merge_d[31:24] = mem_write_data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            wr_merge_d[31:16] = mem_write_data_q[15:0];
        end else begin
            wr_merge_d[15:0] = mem_write_data_q[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            lane_q           <= 2'b00;
            resp_valid_q     <= 1'b0;
            access_error_q   <= 1'b0;
            resp_rdata_q     <= 32'h0;
            mem_addr_q       <= '0;
            mem_write_data_q <= 32'h0;
        end else begin
            resp_valid_q   <= 1'b0;
            access_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req_Valid) begin
                        write_q    <= Req_Write;
                        size_q     <= Req_Size;
                        signed_q   <= Req_Signed;
                        lane_q     <= Req_Addr[1:0];
                        mem_addr_q <= {Req_Addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_err) begin
                            resp_valid_q   <= 1'b1;
                            access_error_q <= 1'b1;
                            resp_rdata_q   <= 32'h0;
                            state_q        <= DONE;
                        end else if (Req_Write) begin
                            mem_write_data_q <= Req_Wdata;
                            state_q          <= (Req_Size == SZ_WORD) ? WR : RD;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        mem_write_data_q <= wr_merge_d;
                        state_q          <= WR;
                    end else begin
                        resp_rdata_q <= rd_extract_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                WR: begin
                    resp_rdata_q <= 32'h0;
                    resp_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Mem_Read       = ~Reset & (state_q == RD);
    assign Mem_Write      = ~Reset & (state_q == WR);
    assign Stall          = ~Reset & (((state_q == IDLE) & Req_Valid) |
                                      (state_q == RD) | (state_q == WR));
    assign Resp_Valid     = resp_valid_q;
    assign Access_Error   = access_error_q;
    assign Resp_Rdata     = resp_rdata_q;
    assign Mem_Addr       = mem_addr_q;
    assign Mem_Write_Data = mem_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_load_store_unit
// Purpose  : Directed vector bench for mem_load_store_unit with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_load_store_unit;

    logic        Clk;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Signed;
    logic [31:0] Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Stall;
    logic        Resp_Valid;
    logic [31:0] Resp_Rdata;
    logic        Access_Error;
    logic [31:0] Mem_Addr;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] Mem_Write_Data;
    logic [31:0] Mem_Read_Data;

    logic        mem_clr;
    logic [31:0] mem_m [16];

    int checks;
    int errors;

    mem_load_store_unit #(.ADDR_WIDTH(32)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req_Valid     (Req_Valid),
        .Req_Write     (Req_Write),
        .Req_Size      (Req_Size),
        .Req_Signed    (Req_Signed),
        .Req_Addr      (Req_Addr),
        .Req_Wdata     (Req_Wdata),
        .Stall         (Stall),
        .Resp_Valid    (Resp_Valid),
        .Resp_Rdata    (Resp_Rdata),
        .Access_Error  (Access_Error),
        .Mem_Addr      (Mem_Addr),
        .Mem_Read      (Mem_Read),
        .Mem_Write     (Mem_Write),
        .Mem_Write_Data(Mem_Write_Data),
        .Mem_Read_Data (Mem_Read_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem_m[i] <= 32'h0;
        end else if (Mem_Write) begin
            mem_m[Mem_Addr[5:2]] <= Mem_Write_Data;
        end
    end
    assign Mem_Read_Data = Mem_Read ? mem_m[Mem_Addr[5:2]] : 32'h0;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_lat;
        logic [31:0] exp_mem;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [3:0] exp_lat, input logic [31:0] exp_mem);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_mem = exp_mem;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int          rd_cnt;
        int          wr_cnt;
        int          lat;
        int          exp_rd;
        int          exp_wr;
        logic        got;
        logic        bad_addr;
        logic        both;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wdat;
        rd_cnt = 0; wr_cnt = 0; lat = 0; got = 1'b0; bad_addr = 1'b0; both = 1'b0;
        err = 1'b0; rdata = 32'h0; wdat = 32'h0;
        exp_rd = v.exp_err ? 0 : (v.wr ? ((v.exp_lat == 4'd3) ? 1 : 0) : 1);
        exp_wr = (!v.exp_err && v.wr) ? 1 : 0;

        @(negedge Clk);
        Req_Valid = 1'b1; Req_Write = v.wr; Req_Size = v.sz; Req_Signed = v.sg;
        Req_Addr = v.addr; Req_Wdata = v.wdata;
        #1;
        chk($sformatf("v%0d stall_at_request", n), {31'h0, Stall}, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            #1;
            if (Mem_Read) rd_cnt++;
            if (Mem_Write) begin
                wr_cnt++;
                wdat = Mem_Write_Data;
            end
            if (Mem_Read && Mem_Write) both = 1'b1;
            if ((Mem_Read || Mem_Write) && Mem_Addr !== {v.addr[31:2], 2'b00}) bad_addr = 1'b1;
            if (Resp_Valid) begin
                got = 1'b1; lat = k; rdata = Resp_Rdata; err = Access_Error;
                Req_Valid = 1'b0;
                break;
            end
        end
        Req_Valid = 1'b0;
        chk($sformatf("v%0d resp_seen", n), {31'h0, got}, 32'h1);
        chk($sformatf("v%0d latency", n), lat, {28'h0, v.exp_lat});
        chk($sformatf("v%0d rdata", n), rdata, v.exp_rdata);
        chk($sformatf("v%0d access_error", n), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d read_cycles", n), rd_cnt, exp_rd);
        chk($sformatf("v%0d write_cycles", n), wr_cnt, exp_wr);
        chk($sformatf("v%0d strobe_addr_ok", n), {31'h0, bad_addr}, 32'h0);
        chk($sformatf("v%0d strobes_exclusive", n), {31'h0, both}, 32'h0);
        if (exp_wr == 1) chk($sformatf("v%0d write_data", n), wdat, v.exp_mem);
        @(negedge Clk);
        #1;
        chk($sformatf("v%0d resp_pulse_end", n), {31'h0, Resp_Valid}, 32'h0);
        chk($sformatf("v%0d error_pulse_end", n), {31'h0, Access_Error}, 32'h0);
        chk($sformatf("v%0d rdata_held", n), Resp_Rdata, v.exp_rdata);
        chk($sformatf("v%0d mem_word", n), mem_m[4], v.exp_mem);
    endtask

    logic [5:0] b2b_stall;
    logic [5:0] b2b_rv;
    logic [5:0] b2b_rd;

    initial begin
        checks = 0; errors = 0;
        Reset = 1'b1; mem_clr = 1'b1;
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b10; Req_Signed = 1'b0;
        Req_Addr = 32'h10; Req_Wdata = 32'hFFFF_FFFF;

        //          wr    sz     sg    addr   wdata         rdata         err  lat  mem
        vecs[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 2, 32'hDEADBEEF);
        vecs[1]  = mk(0, 2'b10, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 32'hDEADBEEF);
        vecs[2]  = mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h00000000, 0, 2, 32'h11223344);
        vecs[3]  = mk(1, 2'b00, 0, 32'h13, 32'h000000A5, 32'h00000000, 0, 3, 32'hA5223344);
        vecs[4]  = mk(0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFFA5, 0, 2, 32'hA5223344);
        vecs[5]  = mk(0, 2'b00, 0, 32'h13, 32'h0,        32'h000000A5, 0, 2, 32'hA5223344);
        vecs[6]  = mk(0, 2'b00, 1, 32'h11, 32'h0,        32'h00000033, 0, 2, 32'hA5223344);
        vecs[7]  = mk(1, 2'b10, 1, 32'h10, 32'h80011234, 32'h00000000, 0, 2, 32'h80011234);
        vecs[8]  = mk(0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF8001, 0, 2, 32'h80011234);
        vecs[9]  = mk(0, 2'b01, 0, 32'h10, 32'h0,        32'h00001234, 0, 2, 32'h80011234);
        vecs[10] = mk(0, 2'b01, 1, 32'h10, 32'h0,        32'h00001234, 0, 2, 32'h80011234);
        vecs[11] = mk(1, 2'b01, 0, 32'h12, 32'h5555BEEF, 32'h00000000, 0, 3, 32'hBEEF1234);
        vecs[12] = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEF1234, 0, 2, 32'hBEEF1234);
        vecs[13] = mk(0, 2'b10, 0, 32'h11, 32'h0,        32'h00000000, 1, 1, 32'hBEEF1234);
        vecs[14] = mk(1, 2'b01, 0, 32'h13, 32'h0000FFFF, 32'h00000000, 1, 1, 32'hBEEF1234);
        vecs[15] = mk(0, 2'b11, 0, 32'h10, 32'h0,        32'h00000000, 1, 1, 32'hBEEF1234);
        vecs[16] = mk(1, 2'b00, 1, 32'h10, 32'hFFFFFF7F, 32'h00000000, 0, 3, 32'hBEEF127F);
        vecs[17] = mk(0, 2'b00, 1, 32'h12, 32'h0,        32'hFFFFFFEF, 0, 2, 32'hBEEF127F);
        vecs[18] = mk(0, 2'b01, 0, 32'h12, 32'h0,        32'h0000BEEF, 0, 2, 32'hBEEF127F);
        vecs[19] = mk(1, 2'b11, 0, 32'h10, 32'h00000000, 32'h00000000, 1, 1, 32'hBEEF127F);
        vecs[20] = mk(1, 2'b10, 0, 32'h12, 32'h00000000, 32'h00000000, 1, 1, 32'hBEEF127F);
        vecs[21] = mk(0, 2'b00, 0, 32'h10, 32'h0,        32'h0000007F, 0, 2, 32'hBEEF127F);
        vecs[22] = mk(0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFBEEF, 0, 2, 32'hBEEF127F);

        // Reset held with a request pending: strobes and Stall must stay low.
        repeat (3) @(negedge Clk);
        #1;
        chk("reset_stall", {31'h0, Stall}, 32'h0);
        chk("reset_mem_read", {31'h0, Mem_Read}, 32'h0);
        chk("reset_mem_write", {31'h0, Mem_Write}, 32'h0);
        Req_Valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0; mem_clr = 1'b0;
        #1;
        chk("reset_resp_valid", {31'h0, Resp_Valid}, 32'h0);
        chk("reset_access_error", {31'h0, Access_Error}, 32'h0);
        chk("reset_resp_rdata", Resp_Rdata, 32'h0);
        chk("reset_mem_addr", Mem_Addr, 32'h0);
        chk("reset_mem_wdata", Mem_Write_Data, 32'h0);
        chk("idle_stall", {31'h0, Stall}, 32'h0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset in the WR cycle of a byte store: the write must be suppressed.
        @(negedge Clk);
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b00; Req_Signed = 1'b0;
        Req_Addr = 32'h13; Req_Wdata = 32'h00000000;
        @(negedge Clk);
        #1;
        chk("rst_wr_rd_phase", {31'h0, Mem_Read}, 32'h1);
        @(negedge Clk);
        #1;
        chk("rst_wr_wr_phase", {31'h0, Mem_Write}, 32'h1);
        Reset = 1'b1; Req_Valid = 1'b0;
        #1;
        chk("rst_wr_write_gated", {31'h0, Mem_Write}, 32'h0);
        chk("rst_wr_stall_gated", {31'h0, Stall}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_wr_stall_after", {31'h0, Stall}, 32'h0);
        chk("rst_wr_resp_valid", {31'h0, Resp_Valid}, 32'h0);
        chk("rst_wr_access_error", {31'h0, Access_Error}, 32'h0);
        chk("rst_wr_resp_rdata", Resp_Rdata, 32'h0);
        chk("rst_wr_mem_addr", Mem_Addr, 32'h0);
        chk("rst_wr_mem_wdata", Mem_Write_Data, 32'h0);
        chk("rst_wr_mem_word", mem_m[4], 32'hBEEF127F);
        @(negedge Clk);
        #1;
        chk("rst_wr_dropped_resp", {31'h0, Resp_Valid}, 32'h0);
        chk("rst_wr_dropped_read", {31'h0, Mem_Read}, 32'h0);
        chk("rst_wr_dropped_write", {31'h0, Mem_Write}, 32'h0);

        // Back-to-back loads with Req_Valid held high throughout.
        b2b_stall = 6'b011011;
        b2b_rv    = 6'b100100;
        b2b_rd    = 6'b010010;
        @(negedge Clk);
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'b10; Req_Signed = 1'b0;
        Req_Addr = 32'h10; Req_Wdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("b2b_stall_c%0d", i), {31'h0, Stall}, {31'h0, b2b_stall[i]});
            chk($sformatf("b2b_resp_c%0d", i), {31'h0, Resp_Valid}, {31'h0, b2b_rv[i]});
            chk($sformatf("b2b_read_c%0d", i), {31'h0, Mem_Read}, {31'h0, b2b_rd[i]});
            if (b2b_rv[i]) chk($sformatf("b2b_rdata_c%0d", i), Resp_Rdata, 32'hBEEF127F);
            if (i == 5) Req_Valid = 1'b0;
            @(negedge Clk);
        end
        #1;
        chk("b2b_tail_stall", {31'h0, Stall}, 32'h0);
        chk("b2b_tail_read", {31'h0, Mem_Read}, 32'h0);
        @(negedge Clk);
        #1;
        chk("b2b_no_extra_resp", {31'h0, Resp_Valid}, 32'h0);
        chk("b2b_no_extra_read", {31'h0, Mem_Read}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
